// File: rtl/cache_wb_buffer.sv
// Write-back buffer between the cache line port and main memory: a FIFO of dirty lines with coalescing and read forwarding.
// Latency: c_gnt one cycle after an accepted write or a buffer read hit; a read miss completes one cycle after m_gnt.
// Backpressure: writes get no c_gnt while full or while matching the draining head; requests are ignored during the c_gnt cycle.
// Build option: define WBUF_STATS_EN to add saturating fwd_cnt / coalesce_cnt / full_stall_cnt outputs.
module cache_wb_buffer #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 15,
  parameter int DEPTH         = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_LEN-1:0]               c_addr,
  input  logic                              c_rd_req,
  input  logic                              c_wr_req,
  input  logic [(32<<LINE_ADDR_LEN)-1:0]    c_wr_line,
  output logic [(32<<LINE_ADDR_LEN)-1:0]    c_rd_line,
  output logic                              c_gnt,
  output logic [ADDR_LEN-1:0]               m_addr,
  output logic                              m_rd_req,
  output logic                              m_wr_req,
  output logic [(32<<LINE_ADDR_LEN)-1:0]    m_wr_line,
  input  logic [(32<<LINE_ADDR_LEN)-1:0]    m_rd_line,
`ifdef WBUF_STATS_EN
  output logic [15:0]                       fwd_cnt,
  output logic [15:0]                       coalesce_cnt,
  output logic [15:0]                       full_stall_cnt,
`endif
  input  logic                              m_gnt
);

  localparam int LINE_W = 32 << LINE_ADDR_LEN;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {M_IDLE, M_READ, M_DRAIN} mstate_t;

  // Buffer storage; an entry is valid between head (oldest) and tail.
  logic [DEPTH-1:0]    ent_vld;
  logic [ADDR_LEN-1:0] ent_addr [DEPTH];
  logic [LINE_W-1:0]   ent_line [DEPTH];
  logic [PTR_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count;

  // Outstanding read miss waiting for the memory port.
  logic                rd_pend;
  logic [ADDR_LEN-1:0] rd_addr;

  mstate_t mstate, mstate_nxt;

  logic                hit;
  logic [PTR_W-1:0]    hit_idx;
  logic                req_ok, wr_sel, rd_sel, head_busy;
  logic                wr_coalesce, wr_push, wr_full_stall;
  logic                rd_hit, rd_miss, rd_done, rd_want, pop;
  logic [ADDR_LEN-1:0] rd_want_addr;
  logic                m_rd_req_nxt, m_wr_req_nxt;
  logic [ADDR_LEN-1:0] m_addr_nxt;
  logic [LINE_W-1:0]   m_wr_line_nxt;

  // Address match against all valid entries; addresses are unique so at most one hits.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_addr[i] == c_addr)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  // Cache-side request decode; nothing is accepted during c_gnt or while a read miss is outstanding.
  always_comb begin
    req_ok        = !c_gnt && !rd_pend;
    wr_sel        = req_ok && c_wr_req;
    rd_sel        = req_ok && c_rd_req && !c_wr_req;
    head_busy     = (mstate == M_DRAIN) && hit && (hit_idx == head);
    wr_coalesce   = wr_sel && hit && !head_busy;
    wr_push       = wr_sel && !hit && (count != FULL);
    wr_full_stall = wr_sel && !hit && (count == FULL);
    rd_hit        = rd_sel && hit;
    rd_miss       = rd_sel && !hit;
    pop           = (mstate == M_DRAIN) && m_gnt;
    rd_done       = (mstate == M_READ) && m_gnt;
    rd_want       = rd_pend || rd_miss;
    rd_want_addr  = rd_pend ? rd_addr : c_addr;
  end

  // Memory FSM next state and next registered memory-port outputs; read misses win over draining.
  always_comb begin
    mstate_nxt    = mstate;
    m_rd_req_nxt  = m_rd_req;
    m_wr_req_nxt  = m_wr_req;
    m_addr_nxt    = m_addr;
    m_wr_line_nxt = m_wr_line;
    case (mstate)
      M_IDLE: begin
        if (rd_want) begin
          mstate_nxt   = M_READ;
          m_rd_req_nxt = 1'b1;
          m_addr_nxt   = rd_want_addr;
        end else if (count != '0) begin
          mstate_nxt   = M_DRAIN;
          m_wr_req_nxt = 1'b1;
          m_addr_nxt   = ent_addr[head];
          // A coalesce into the head in this same cycle must reach memory, not the stale line.
          m_wr_line_nxt = (wr_coalesce && (hit_idx == head)) ? c_wr_line : ent_line[head];
        end
      end
      M_READ: begin
        if (m_gnt) begin
          mstate_nxt   = M_IDLE;
          m_rd_req_nxt = 1'b0;
        end
      end
      M_DRAIN: begin
        if (m_gnt) begin
          mstate_nxt   = M_IDLE;
          m_wr_req_nxt = 1'b0;
        end
      end
      default: begin
        mstate_nxt   = M_IDLE;
        m_rd_req_nxt = 1'b0;
        m_wr_req_nxt = 1'b0;
      end
    endcase
  end

  // Memory FSM state and registered memory-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstate    <= M_IDLE;
      m_rd_req  <= 1'b0;
      m_wr_req  <= 1'b0;
      m_addr    <= '0;
      m_wr_line <= '0;
    end else begin
      mstate    <= mstate_nxt;
      m_rd_req  <= m_rd_req_nxt;
      m_wr_req  <= m_wr_req_nxt;
      m_addr    <= m_addr_nxt;
      m_wr_line <= m_wr_line_nxt;
    end
  end

  // FIFO storage: push at tail, coalesce in place, pop the head when its drain is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_vld <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_line[i] <= '0;
      end
    end else begin
      if (wr_push) begin
        ent_vld[tail]  <= 1'b1;
        ent_addr[tail] <= c_addr;
        ent_line[tail] <= c_wr_line;
        tail           <= tail + 1'b1;
      end
      if (wr_coalesce) begin
        ent_line[hit_idx] <= c_wr_line;
      end
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      case ({wr_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Cache-side completion: gnt pulse, returned line and read-miss bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_gnt     <= 1'b0;
      c_rd_line <= '0;
      rd_pend   <= 1'b0;
      rd_addr   <= '0;
    end else begin
      c_gnt <= wr_coalesce || wr_push || rd_hit || rd_done;
      if (rd_hit) begin
        c_rd_line <= ent_line[hit_idx];
      end else if (rd_done) begin
        c_rd_line <= m_rd_line;
      end
      if (rd_miss) begin
        rd_pend <= 1'b1;
        rd_addr <= c_addr;
      end else if (rd_done) begin
        rd_pend <= 1'b0;
      end
    end
  end

`ifdef WBUF_STATS_EN
  // Saturating event counters for forwards, coalesces and full-stall cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_cnt        <= '0;
      coalesce_cnt   <= '0;
      full_stall_cnt <= '0;
    end else begin
      if (rd_hit && (fwd_cnt != 16'hFFFF)) begin
        fwd_cnt <= fwd_cnt + 16'd1;
      end
      if (wr_coalesce && (coalesce_cnt != 16'hFFFF)) begin
        coalesce_cnt <= coalesce_cnt + 16'd1;
      end
      if (wr_full_stall && (full_stall_cnt != 16'hFFFF)) begin
        full_stall_cnt <= full_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
